// File: rtl/random_burst_pkg.sv
// random_burst_pkg: shared FSM state encoding and counter widths for random_burst_source
package random_burst_pkg;
    localparam int BURST_CNT_W = 16;
    typedef enum logic [2:0] {
        IDLE,
        DRAW_GAP,
        LOAD_GAP,
        GAP,
        DRAW_LEN,
        LOAD_LEN,
        BURST
    } state_t;
endpackage

// File: rtl/rbs_down_counter.sv
// rbs_down_counter: loadable down-counter with a terminal-one flag
module rbs_down_counter #(
    parameter int w = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [w-1:0] load_val,
    output logic [w-1:0] value,
    output logic         is_one
);
    always_ff @(posedge clk) begin
        if (rst) value <= '0;
        else if (load) value <= load_val;
        else if (dec) value <= value - w'(1);
    end
    assign is_one = value == w'(1);
endmodule

// File: rtl/random_burst_source.sv
// random_burst_source: draws a gap and a burst length from an upstream random source,
// then emits an incrementing valid/ready burst whose final beat carries OUT_LAST.
module random_burst_source
    import random_burst_pkg::*;
#(
    parameter int width  = 8,
    parameter int rwidth = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   ENABLE,
    output logic                   RND_EN,
    input  logic [rwidth-1:0]      RND_IN,
    output logic [width-1:0]       OUT_DATA,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic                   OUT_LAST,
    output logic                   BUSY,
    output logic [BURST_CNT_W-1:0] BURST_CNT
);
    state_t            state;
    logic [width-1:0]  seq;
    logic [rwidth-1:0] gap_val;
    logic [rwidth:0]   beat_val;
    logic              gap_one, beat_one, hs, unused_vals;
    assign hs = state == BURST && OUT_READY;
    // beat count is one bit wider so an all-ones draw becomes 2^rwidth beats
    rbs_down_counter #(.w(rwidth)) u_gap (
        .clk(CLK), .rst(RST), .load(state == LOAD_GAP), .dec(state == GAP),
        .load_val(RND_IN), .value(gap_val), .is_one(gap_one)
    );
    rbs_down_counter #(.w(rwidth + 1)) u_beat (
        .clk(CLK), .rst(RST), .load(state == LOAD_LEN), .dec(hs),
        .load_val({1'b0, RND_IN} + (rwidth + 1)'(1)), .value(beat_val), .is_one(beat_one)
    );
    assign unused_vals = ^{gap_val, beat_val};
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            seq       <= '0;
            BURST_CNT <= '0;
        end else begin
            case (state)
                IDLE:     if (ENABLE) state <= DRAW_GAP;
                DRAW_GAP: state <= LOAD_GAP;
                LOAD_GAP: state <= RND_IN != '0 ? GAP : DRAW_LEN;
                GAP:      if (gap_one) state <= DRAW_LEN;
                DRAW_LEN: state <= LOAD_LEN;
                LOAD_LEN: state <= BURST;
                BURST:    if (hs && beat_one) state <= ENABLE ? DRAW_GAP : IDLE;
                default:  state <= IDLE;
            endcase
            if (hs) seq <= seq + width'(1);
            if (hs && beat_one) BURST_CNT <= BURST_CNT + BURST_CNT_W'(1);
        end
    end
    assign RND_EN    = state == DRAW_GAP || state == DRAW_LEN;
    assign OUT_VALID = state == BURST;
    assign OUT_LAST  = state == BURST && beat_one;
    assign OUT_DATA  = seq;
    assign BUSY      = state != IDLE;
endmodule

// File: tb/tb_random_burst_source.sv
// tb_random_burst_source: directed and randomized bursts checked cycle by cycle against
// a timeline model derived from the drawn gap/length values.
module tb_random_burst_source;
    logic        CLK = 0, RST = 1, ENABLE = 0, OUT_READY = 0;
    logic [7:0]  RND_IN = 0;
    logic        RND_EN, OUT_VALID, OUT_LAST, BUSY;
    logic [7:0]  OUT_DATA;
    logic [15:0] BURST_CNT;
    logic [7:0]  rnd_q[$];
    logic [7:0]  exp_seq = 0;
    logic [15:0] exp_bc = 0;
    logic        pend;
    int vectors = 0, errors = 0;

    random_burst_source #(.width(8), .rwidth(8)) dut (
        .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .RND_EN(RND_EN), .RND_IN(RND_IN),
        .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_LAST(OUT_LAST), .BUSY(BUSY), .BURST_CNT(BURST_CNT)
    );

    always #5 CLK = ~CLK;

    // upstream source: next queued value appears the cycle after a request, noise otherwise
    always @(posedge CLK) begin
        pend = RND_EN;
        #1;
        if (pend) RND_IN = rnd_q.size() != 0 ? rnd_q.pop_front() : 8'd0;
        else RND_IN = 8'($urandom);
    end

    task automatic do_reset();
        RST = 1; ENABLE = 0; OUT_READY = 0;
        repeat (2) @(negedge CLK);
        RST = 0; exp_seq = 0; exp_bc = 0;
    endtask

    // entered at the negedge of cycle 0 (ENABLE about to be sampled high)
    task automatic burst(input int g, input int len, input bit keep_en, input int pct, input int stall0);
        int beats, stall;
        bit rdy, done;
        rnd_q.push_back(8'(g));
        rnd_q.push_back(8'(len - 1));
        for (int c = 1; c <= 4 + g; c++) begin
            @(negedge CLK);
            vectors++;
            if (RND_EN !== (c == 1 || c == 3 + g)) begin
                errors++; $display("FAIL rnd_en g=%0d cyc=%0d got=%b want=%b", g, c, RND_EN, (c == 1 || c == 3 + g));
            end
            vectors++;
            if ({OUT_VALID, BUSY} !== 2'b01) begin
                errors++; $display("FAIL pre_burst g=%0d cyc=%0d valid,busy got=%b want=01", g, c, {OUT_VALID, BUSY});
            end
            if (!keep_en && c == (g > 0 ? 3 : 1)) ENABLE = 0;
            OUT_READY = 1'($urandom_range(1));
        end
        beats = 0; stall = 0; done = 0;
        while (!done) begin
            @(negedge CLK);
            vectors++;
            if ({OUT_VALID, RND_EN} !== 2'b10) begin
                errors++; $display("FAIL burst_valid beat=%0d valid,rnd_en got=%b want=10", beats, {OUT_VALID, RND_EN});
            end
            vectors++;
            if (OUT_DATA !== exp_seq) begin
                errors++; $display("FAIL data beat=%0d got=%0d want=%0d", beats, OUT_DATA, exp_seq);
            end
            vectors++;
            if (OUT_LAST !== (beats == len - 1)) begin
                errors++; $display("FAIL last beat=%0d/%0d got=%b want=%b", beats, len, OUT_LAST, (beats == len - 1));
            end
            vectors++;
            if (BURST_CNT !== exp_bc) begin
                errors++; $display("FAIL burst_cnt_mid got=%0d want=%0d", BURST_CNT, exp_bc);
            end
            rdy = (beats == 0 && stall < stall0) ? 1'b0 : (stall >= 3 || $urandom_range(99) < pct);
            OUT_READY = rdy;
            if (rdy) begin
                exp_seq++; stall = 0; beats++;
                if (beats == len) begin exp_bc++; done = 1; end
            end else stall++;
        end
        if (!keep_en) begin
            for (int c = 0; c < 3; c++) begin
                @(negedge CLK);
                OUT_READY = 1'($urandom_range(1));
                vectors++;
                if ({OUT_VALID, BUSY, RND_EN} !== 3'b000) begin
                    errors++; $display("FAIL idle_after cyc=%0d valid,busy,rnd_en got=%b want=000", c, {OUT_VALID, BUSY, RND_EN});
                end
            end
            vectors++;
            if (BURST_CNT !== exp_bc) begin
                errors++; $display("FAIL burst_cnt_end got=%0d want=%0d", BURST_CNT, exp_bc);
            end
        end
    endtask

    task automatic test_reset();
        RST = 1;
        repeat (2) @(negedge CLK);
        vectors++;
        if ({RND_EN, OUT_VALID, OUT_LAST, BUSY} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl got=%b want=0000", {RND_EN, OUT_VALID, OUT_LAST, BUSY});
        end
        vectors++;
        if (OUT_DATA !== 8'd0) begin errors++; $display("FAIL reset_data got=%0d want=0", OUT_DATA); end
        vectors++;
        if (BURST_CNT !== 16'd0) begin errors++; $display("FAIL reset_bcnt got=%0d want=0", BURST_CNT); end
        RST = 0; exp_seq = 0; exp_bc = 0;
    endtask

    task automatic test_basic();
        do_reset(); ENABLE = 1;
        burst(0, 3, 0, 100, 0);
    endtask

    task automatic test_stall();
        do_reset(); ENABLE = 1;
        burst(2, 1, 0, 100, 4);
    endtask

    task automatic test_wrap_back_to_back();
        do_reset(); ENABLE = 1;
        burst(1, 256, 1, 100, 0);
        burst(0, 2, 1, 80, 0);
        burst(3, 3, 0, 60, 0);
    endtask

    task automatic test_enable_drop();
        do_reset(); ENABLE = 1;
        burst(6, 2, 0, 50, 0);
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset(); ENABLE = 1;
        rnd_q.push_back(8'd0);
        rnd_q.push_back(8'd3);
        n = 0;
        do begin @(negedge CLK); n++; end while (OUT_VALID !== 1'b1 && n < 20);
        vectors++;
        if (OUT_VALID !== 1'b1) begin errors++; $display("FAIL rmid_start got valid=%b want=1", OUT_VALID); end
        ENABLE = 0; OUT_READY = 1;
        @(negedge CLK);
        vectors++;
        if (OUT_DATA !== 8'd1) begin errors++; $display("FAIL rmid_beat2 got=%0d want=1", OUT_DATA); end
        RST = 1;
        @(negedge CLK);
        vectors++;
        if ({OUT_VALID, BUSY, RND_EN} !== 3'b000) begin
            errors++; $display("FAIL rmid_ctrl valid,busy,rnd_en got=%b want=000", {OUT_VALID, BUSY, RND_EN});
        end
        vectors++;
        if (OUT_DATA !== 8'd0 || BURST_CNT !== 16'd0) begin
            errors++; $display("FAIL rmid_state data=%0d bcnt=%0d want 0,0", OUT_DATA, BURST_CNT);
        end
        RST = 0; OUT_READY = 0; exp_seq = 0; exp_bc = 0;
        rnd_q.delete();
    endtask

    task automatic test_random();
        bit keep, prev_keep;
        int g, len;
        do_reset();
        prev_keep = 0;
        for (int i = 0; i < 40; i++) begin
            g   = $urandom_range(9) == 0 ? $urandom_range(255) : $urandom_range(6);
            len = $urandom_range(9) == 0 ? $urandom_range(256, 1) : $urandom_range(12, 1);
            keep = i < 39 && $urandom_range(1) == 1;
            if (!prev_keep) ENABLE = 1;
            burst(g, len, keep, 70, 0);
            prev_keep = keep;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_wrap_back_to_back();
        test_enable_drop();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/random_burst_source.md
# random_burst_source

Stimulus-side traffic generator that sits directly downstream of a constrained-random value source. It pulls random values one at a time through an enable/value pair, using one as an idle-gap length and the next as a burst length. It then emits a valid/ready stream of incrementing data beats, with the final beat flagged LAST. Benches use it to drive DUT inputs with randomized burst and gap shapes. Randomness comes entirely from the upstream source; the range of those values is fixed by how that source is parameterized.

## Interface
Parameters:
- width, 8, data beat width; the sequence counter wraps at 2^width.
- rwidth, 8, width of the random input; gap range 0..2^rwidth-1, burst length range 1..2^rwidth.

Ports:
- CLK  input  1  clock; all state changes on the posedge.
- RST  input  1  reset; synchronous, active-high.
- ENABLE  input  1  allows new bursts to start; sampled in IDLE and at burst end.
- RND_EN  output  1  one-cycle request to the upstream random source to advance.
- RND_IN  input  rwidth  random value from upstream, treated as unsigned; valid the cycle after RND_EN.
- OUT_DATA  output  width  beat payload.
- OUT_VALID  output  1  beat present.
- OUT_READY  input  1  consumer accepts the beat.
- OUT_LAST  output  1  final beat of the burst; qualified by OUT_VALID.
- BUSY  output  1  high in every state except IDLE.
- BURST_CNT  output  16  number of completed bursts; wraps at 2^16.

## Operation
- States and transitions:
  - IDLE: go to DRAW_GAP if ENABLE is high.
  - DRAW_GAP: assert RND_EN; go to LOAD_GAP.
  - LOAD_GAP: gap_cnt <= RND_IN. Go to GAP if RND_IN != 0, else to DRAW_LEN.
  - GAP: decrement gap_cnt; go to DRAW_LEN when gap_cnt == 1.
  - DRAW_LEN: assert RND_EN; go to LOAD_LEN.
  - LOAD_LEN: beat_cnt <= RND_IN + 1, held in rwidth+1 bits so that all-ones does not overflow; go to BURST.
  - BURST: emit beats. On the final handshake, go to DRAW_GAP if ENABLE is high, else to IDLE.
- RND_EN is high only in DRAW_GAP and DRAW_LEN, so exactly two pulses are issued per burst.
- A handshake is a cycle with OUT_VALID && OUT_READY. On each handshake, seq increments (wrapping mod 2^width) and beat_cnt decrements.
- OUT_VALID is high exactly while in BURST. OUT_DATA = seq.
- OUT_LAST = (beat_cnt == 1) in BURST, else 0.
- seq persists across bursts and across ENABLE toggles; only RST clears it.
- Stall rule: while OUT_VALID && !OUT_READY, OUT_DATA and OUT_LAST must hold stable.
- ENABLE dropping in any non-IDLE state has no effect. The current gap and burst run to completion; ENABLE is re-checked only at burst end.
- BURST_CNT increments on the handshake of each LAST beat.

## Timing
- Reset values: state IDLE, RND_EN 0, OUT_VALID 0, OUT_LAST 0, OUT_DATA 0, seq 0, BUSY 0, BURST_CNT 0, gap_cnt 0, beat_cnt 0.
- RST mid-burst: the next cycle is IDLE with OUT_VALID 0. No partial-burst cleanup; the burst is abandoned.
- Latency, with cycle 0 = the IDLE cycle in which ENABLE is sampled high:
  - DRAW_GAP in cycle 1, LOAD_GAP in cycle 2.
  - Gap g occupies cycles 3..2+g.
  - DRAW_LEN in 3+g, LOAD_LEN in 4+g.
  - First OUT_VALID in cycle 5+g.
- Back-to-back bursts: after the LAST handshake, the next first beat comes no earlier than 4+g cycles later.
- With OUT_READY held high, a burst of length L occupies exactly L consecutive valid cycles.
- RND_IN is sampled only in LOAD_GAP and LOAD_LEN; all other values on it are ignored.

## Structure
- Shared package random_burst_pkg holds the state enum (7 states, 3-bit encoding) and the BURST_CNT width constant.
- One sub-module, rbs_down_counter: a loadable down-counter with load, dec, value and is_one outputs. It is instantiated twice, once for gap_cnt and once for beat_cnt (width rwidth+1).
- Everything else (FSM, seq, BURST_CNT) lives in the top module.

## Test plan
- Gap 0 then length 3, READY=1, ENABLE=1 from cycle 0:
  - RND_EN pulses in cycles 1 and 3.
  - OUT_DATA 0,1,2 in cycles 5,6,7, with LAST in cycle 7.
  - BURST_CNT=1 in cycle 8.
- Gap 2 then length 1, READY stuck low for 4 cycles once VALID rises:
  - OUT_DATA=0 and LAST=1 held stable for 4 cycles.
  - The beat completes on the first READY cycle.
- RND_IN=8'hFF for the length draw: exactly 256 beats; seq wraps 255 -> 0 on the last beat.
- ENABLE dropped during GAP:
  - The burst still completes.
  - The FSM returns to IDLE, BUSY=0, and no third RND_EN pulse is issued.
- RST asserted on the 2nd beat of a 4-beat burst:
  - Next cycle OUT_VALID=0, seq=0, BURST_CNT=0, state IDLE.
- Random regression: the bench's reference model checks that beats per burst = sampled length + 1 and gap cycles = sampled gap.
